// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, pixel/address types and 640x480 timing constants.
package vga_pkg;

    localparam int unsigned FB_W       = 160;
    localparam int unsigned FB_H       = 120;
    localparam int unsigned SCALE_LOG2 = 2;
    localparam int unsigned DW         = 8;
    localparam int unsigned AW         = 15;
    localparam int unsigned FB_WORDS   = FB_W * FB_H;

    // 640x480@60 timing, shared with the timing generator
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [DW-1:0] rgb332_t;
    typedef logic [AW-1:0] fb_addr_t;

    // Row base address for a 160-wide framebuffer: row*160 = (row<<7) + (row<<5)
    function automatic fb_addr_t fb_row_base(input logic [7:0] row);
        fb_addr_t r;
        r = fb_addr_t'(row);
        return (r << 7) + (r << 5);
    endfunction

endpackage

// File: rtl/vga_fb_rr_arb.sv
// Two-way round-robin arbiter for the RAM slots left free by the display fetch.
module vga_fb_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       slot_free,
    output logic [1:0] gnt
);

    // 1 means client 1 was granted most recently, so client 0 wins the first tie
    logic last_gnt;

    // Grant a lone requester; on a tie, grant the client not granted last
    always_comb begin
        gnt = '0;
        if (slot_free) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
    end

    // Remember the winner, only when a grant is actually issued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= 1'b1;
        end else if (|gnt) begin
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM sharing between display fetch (absolute priority) and two clients.
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic     hsync,
    input  logic     vsync,
    input  logic     de,
    output logic     hsync_o,
    output logic     vsync_o,
    output logic     de_o,
    output rgb332_t  rgb_o,
    input  logic     c0_req,
    input  logic     c0_we,
    input  fb_addr_t c0_addr,
    input  rgb332_t  c0_wdata,
    output logic     c0_gnt,
    output logic     c0_rvalid,
    output rgb332_t  c0_rdata,
    input  logic     c1_req,
    input  logic     c1_we,
    input  fb_addr_t c1_addr,
    input  rgb332_t  c1_wdata,
    output logic     c1_gnt,
    output logic     c1_rvalid,
    output rgb332_t  c1_rdata,
    output logic     mem_en,
    output logic     mem_we,
    output fb_addr_t mem_addr,
    output rgb332_t  mem_wdata,
    input  rgb332_t  mem_rdata
);

    logic       display_slot;
    logic       slot_free;
    fb_addr_t   fetch_addr;
    logic [1:0] gnt;
    logic       sel_we;
    fb_addr_t   sel_addr;
    rgb332_t    sel_wdata;
    logic       in_range;
    logic [1:0] rd_pend;
    logic       rd_zero;
    logic       fetch_d;
    rgb332_t    pix_hold;
    logic [1:0] hs_pipe;
    logic [1:0] vs_pipe;
    logic [1:0] de_pipe;
    logic       unused_sy_lsb;

    assign unused_sy_lsb = ^sy[SCALE_LOG2-1:0];

    assign display_slot = de && (sx[SCALE_LOG2-1:0] == '0);
    assign slot_free    = reset_n && !display_slot;
    assign fetch_addr   = fb_row_base(sy[9:SCALE_LOG2]) + fb_addr_t'(sx[9:SCALE_LOG2]);

    vga_fb_rr_arb u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       ({c1_req, c0_req}),
        .slot_free (slot_free),
        .gnt       (gnt)
    );

    assign c0_gnt = gnt[0];
    assign c1_gnt = gnt[1];

    assign sel_we    = gnt[1] ? c1_we    : c0_we;
    assign sel_addr  = gnt[1] ? c1_addr  : c0_addr;
    assign sel_wdata = gnt[1] ? c1_wdata : c0_wdata;
    assign in_range  = sel_addr < fb_addr_t'(FB_WORDS);

    // RAM port mux: display fetch first, then the granted client (dropped if out of range)
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = fetch_addr;
        mem_wdata = '0;
        if (reset_n && display_slot) begin
            mem_en = 1'b1;
        end else if (|gnt) begin
            mem_en    = in_range;
            mem_we    = sel_we;
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
        end
    end

    // Track reads granted this cycle so their data can be returned next cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= '0;
            rd_zero <= 1'b0;
        end else begin
            rd_pend <= gnt & ~{c1_we, c0_we};
            rd_zero <= !in_range;
        end
    end

    assign c0_rvalid = rd_pend[0];
    assign c1_rvalid = rd_pend[1];
    assign c0_rdata  = (rd_pend[0] && !rd_zero) ? mem_rdata : '0;
    assign c1_rdata  = (rd_pend[1] && !rd_zero) ? mem_rdata : '0;

    // Capture fetched pixel one cycle after the fetch and delay syncs by two cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_d  <= 1'b0;
            pix_hold <= '0;
            hs_pipe  <= 2'b11;
            vs_pipe  <= 2'b11;
            de_pipe  <= 2'b00;
        end else begin
            fetch_d <= display_slot;
            if (fetch_d) begin
                pix_hold <= mem_rdata;
            end
            hs_pipe <= {hs_pipe[0], hsync};
            vs_pipe <= {vs_pipe[0], vsync};
            de_pipe <= {de_pipe[0], de};
        end
    end

    assign hsync_o = hs_pipe[1];
    assign vsync_o = vs_pipe[1];
    assign de_o    = de_pipe[1];
    assign rgb_o   = de_o ? pix_hold : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench: a behavioural model predicts grants, RAM port, read returns and pixels.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  sx, sy;
    logic        hsync, vsync, de;
    logic        hsync_o, vsync_o, de_o;
    logic [7:0]  rgb_o;
    logic        c0_req, c0_we, c0_gnt, c0_rvalid;
    logic [14:0] c0_addr;
    logic [7:0]  c0_wdata, c0_rdata;
    logic        c1_req, c1_we, c1_gnt, c1_rvalid;
    logic [14:0] c1_addr;
    logic [7:0]  c1_wdata, c1_rdata;
    logic        mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    vga_fb_arbiter dut (
        .clk(clk), .reset_n(reset_n), .sx(sx), .sy(sy),
        .hsync(hsync), .vsync(vsync), .de(de),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .rgb_o(rgb_o),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical single-port synchronous RAM driven by the DUT
    logic [7:0] ram [0:19199];
    always @(posedge clk) begin
        if (mem_en && mem_addr < 15'd19200) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference framebuffer contents as the model believes them to be
    logic [7:0] gold [0:19199];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct { int due; bit g0; bit g1; bit en; bit we; int addr; int wdata; } gexp_t;
    typedef struct { int due; bit de; bit hs; bit vs; int rgb; } pexp_t;
    typedef struct { int due; int data; } rexp_t;

    gexp_t gq[$];
    pexp_t pq[$];
    rexp_t rq0[$];
    rexp_t rq1[$];

    bit mon_en = 0;
    bit act[2];
    bit cwe[2];
    int caddr[2];
    int cwd[2];
    bit rand_en = 0;
    int req_pct = 0;
    int last_client = 1;
    int disp_val = 0;

    task automatic new_cmd(input int k);
        int sel;
        sel = $urandom_range(0, 9);
        cwe[k] = 1'($urandom_range(0, 1));
        case (sel)
            0: caddr[k] = 19199;
            1: caddr[k] = 19200;
            2: caddr[k] = $urandom_range(19200, 32767);
            3, 4: caddr[k] = $urandom_range(0, 639);
            default: caddr[k] = $urandom_range(0, 19199);
        endcase
        cwd[k] = $urandom_range(0, 255);
        act[k] = 1;
    endtask

    task automatic issue(input int k, input bit we, input int addr, input int wd);
        cwe[k] = we; caddr[k] = addr; cwd[k] = wd; act[k] = 1;
    endtask

    // Apply one cycle of stimulus and push what the DUT must show for it
    task automatic drive_model(input int x, input int y);
        bit vde, vfetch;
        int g, fa;
        gexp_t ge;
        pexp_t pe;
        rexp_t re;
        if (rand_en)
            for (int k = 0; k < 2; k++)
                if (!act[k] && $urandom_range(0, 99) < req_pct) new_cmd(k);
        vde = (x < 640) && (y < 480);
        sx = 10'(x); sy = 10'(y); de = vde;
        hsync = !(x >= 656 && x < 752);
        vsync = !(y >= 490 && y < 492);
        c0_req = act[0]; c0_we = cwe[0]; c0_addr = 15'(caddr[0]); c0_wdata = 8'(cwd[0]);
        c1_req = act[1]; c1_we = cwe[1]; c1_addr = 15'(caddr[1]); c1_wdata = 8'(cwd[1]);
        vfetch = vde && (x % 4 == 0);
        fa = (y / 4) * 160 + x / 4;
        g = -1;
        if (!vfetch) begin
            if (act[0] && act[1]) g = 1 - last_client;
            else if (act[0])      g = 0;
            else if (act[1])      g = 1;
        end
        ge.due = cyc; ge.g0 = (g == 0); ge.g1 = (g == 1);
        ge.en = 0; ge.we = 0; ge.addr = 0; ge.wdata = 0;
        if (vfetch) begin
            ge.en = 1; ge.addr = fa;
        end else if (g >= 0) begin
            ge.en = caddr[g] < 19200; ge.we = cwe[g]; ge.addr = caddr[g]; ge.wdata = cwd[g];
        end
        gq.push_back(ge);
        if (g >= 0) begin
            last_client = g;
            act[g] = 0;
            if (!cwe[g]) begin
                re.due = cyc + 1;
                re.data = (caddr[g] < 19200) ? int'(gold[caddr[g]]) : 0;
                if (g == 0) rq0.push_back(re); else rq1.push_back(re);
            end else if (caddr[g] < 19200) begin
                gold[caddr[g]] = 8'(cwd[g]);
            end
        end
        if (vfetch) disp_val = gold[fa];
        pe.due = cyc + 2; pe.de = vde; pe.hs = hsync; pe.vs = vsync;
        pe.rgb = vde ? disp_val : 0;
        pq.push_back(pe);
    endtask

    task automatic step(input int x, input int y);
        drive_model(x, y);
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int y);
        for (int x = 0; x < 800; x++) step(x, y);
    endtask

    task automatic run_blank(input int n);
        for (int i = 0; i < n; i++) step(700, 500);
    endtask

    task automatic clear_model();
        gq.delete(); pq.delete(); rq0.delete(); rq1.delete();
        act[0] = 0; act[1] = 0;
        last_client = 1;
        disp_val = 0;
    endtask

    task automatic idle_inputs();
        sx = 10'd700; sy = 10'd500; de = 0; hsync = 1; vsync = 1;
        c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
        c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
    endtask

    gexp_t mg;
    pexp_t mp;
    rexp_t mr;

    // Monitor: pop expectations that fall due this cycle and compare
    always @(negedge clk) begin
        if (mon_en) begin
            while (gq.size() > 0 && gq[0].due <= cyc) begin
                mg = gq.pop_front();
                if (mg.due == cyc) begin
                    check("c0_gnt", int'(c0_gnt), int'(mg.g0));
                    check("c1_gnt", int'(c1_gnt), int'(mg.g1));
                    check("mem_en", int'(mem_en), int'(mg.en));
                    if (mg.en) begin
                        check("mem_we", int'(mem_we), int'(mg.we));
                        check("mem_addr", int'(mem_addr), mg.addr);
                        if (mg.we) check("mem_wdata", int'(mem_wdata), mg.wdata);
                    end
                end
            end
            while (pq.size() > 0 && pq[0].due <= cyc) begin
                mp = pq.pop_front();
                if (mp.due == cyc) begin
                    check("de_o", int'(de_o), int'(mp.de));
                    check("hsync_o", int'(hsync_o), int'(mp.hs));
                    check("vsync_o", int'(vsync_o), int'(mp.vs));
                    check("rgb_o", int'(rgb_o), mp.rgb);
                end
            end
            if (c0_rvalid) begin
                if (rq0.size() == 0) check("c0_rvalid_spurious", 1, 0);
                else begin
                    mr = rq0.pop_front();
                    check("c0_rvalid_cycle", cyc, mr.due);
                    check("c0_rdata", int'(c0_rdata), mr.data);
                end
            end else if (rq0.size() > 0 && rq0[0].due <= cyc) begin
                mr = rq0.pop_front();
                check("c0_rvalid_missing", 0, 1);
            end
            if (c1_rvalid) begin
                if (rq1.size() == 0) check("c1_rvalid_spurious", 1, 0);
                else begin
                    mr = rq1.pop_front();
                    check("c1_rvalid_cycle", cyc, mr.due);
                    check("c1_rdata", int'(c1_rdata), mr.data);
                end
            end else if (rq1.size() > 0 && rq1[0].due <= cyc) begin
                mr = rq1.pop_front();
                check("c1_rvalid_missing", 0, 1);
            end
        end
    end

    initial begin
        for (int i = 0; i < 19200; i++) begin
            gold[i] = 8'($urandom_range(0, 255));
            ram[i] = gold[i];
        end
        gold[0] = 8'h11; ram[0] = 8'h11;
        gold[1] = 8'h22; ram[1] = 8'h22;

        // Reset held with both clients requesting and a display slot presented
        idle_inputs();
        reset_n = 0;
        sx = 10'd0; sy = 10'd0; de = 1;
        c0_req = 1; c0_addr = 15'd5; c1_req = 1; c1_addr = 15'd6;
        repeat (3) @(posedge clk);
        #3;
        check("rst_c0_gnt", int'(c0_gnt), 0);
        check("rst_c1_gnt", int'(c1_gnt), 0);
        check("rst_mem_en", int'(mem_en), 0);
        check("rst_hsync_o", int'(hsync_o), 1);
        check("rst_vsync_o", int'(vsync_o), 1);
        check("rst_de_o", int'(de_o), 0);
        check("rst_rgb_o", int'(rgb_o), 0);
        check("rst_c0_rvalid", int'(c0_rvalid), 0);
        check("rst_c1_rvalid", int'(c1_rvalid), 0);
        check("rst_c0_rdata", int'(c0_rdata), 0);
        check("rst_c1_rdata", int'(c1_rdata), 0);

        @(posedge clk); #1;
        idle_inputs();
        clear_model();
        reset_n = 1;
        mon_en = 1;

        // Both clients hammering in blanking: strict alternation starting with c0
        rand_en = 1; req_pct = 100;
        run_blank(8);

        // Random traffic across active lines, the bottom-right corner and blanking lines
        req_pct = 35;
        run_line(0);
        run_line(3);
        run_line(4);
        run_line($urandom_range(5, 478));
        req_pct = 80;
        run_line($urandom_range(5, 478));
        run_line(479);
        run_line(491);

        // Directed range-boundary reads and an out-of-range write in blanking
        rand_en = 0;
        run_blank(4);
        issue(1, 0, 19199, 0);
        run_blank(3);
        issue(1, 0, 19200, 0);
        run_blank(3);
        issue(0, 1, 19200, 8'h5A);
        run_blank(3);
        issue(0, 0, 19200, 0);
        run_blank(3);

        // Reset lands after a c0 read grant, before its data returns
        issue(0, 0, 123, 0);
        drive_model(700, 500);
        @(negedge clk); #1;
        mon_en = 0;
        reset_n = 0;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mid_rst_c0_rvalid", int'(c0_rvalid), 0);
            check("mid_rst_c0_gnt", int'(c0_gnt), 0);
        end
        idle_inputs();
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_c0_rvalid", int'(c0_rvalid), 0);
        end
        clear_model();
        mon_en = 1;

        // Traffic resumes after the mid-transaction reset
        rand_en = 1; req_pct = 50;
        run_line(479);
        rand_en = 0;
        run_blank(6);

        check("rd_queue_drained", rq0.size() + rq1.size(), 0);
        check("gnt_queue_drained", gq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
